// File: rtl/sort_pkg.sv
// Shared definitions for the selection-sort engine family: FSM encoding and sort order.
package sort_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      ANCHOR = 3'd2,
      SCAN   = 3'd3,
      SWAP   = 3'd4,
      SHOW   = 3'd5
   } state_e;

   localparam logic ORDER_ASC  = 1'b0;
   localparam logic ORDER_DESC = 1'b1;

endpackage

// File: rtl/sort_engine_if.sv
// Load and result streams of the sort engine; the engine is the slave on both.
interface sort_engine_if #(parameter int unsigned WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/sort_cmp.sv
// Combinational "a is strictly better than b" for a given order and signedness.
module sort_cmp
   import sort_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter bit          SIGNED = 1'b0
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             desc_i,
   output logic             better_c
);

   logic lt;
   logic gt;

   always_comb begin
      if (SIGNED) begin
         lt = $signed(a_i) < $signed(b_i);
         gt = $signed(a_i) > $signed(b_i);
      end else begin
         lt = a_i < b_i;
         gt = a_i > b_i;
      end
      better_c = (desc_i == ORDER_DESC) ? gt : lt;
   end

endmodule

// File: rtl/sort_engine.sv
// Self-controlled selection sorter: load N words, sort in place, stream them out.
module sort_engine
   import sort_pkg::*;
#(
   parameter int unsigned N      = 5,
   parameter int unsigned WIDTH  = 8,
   parameter bit          SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               descending,
   sort_engine_if.slave       bus,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   localparam int unsigned    AW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0]  LAST = AW'(N - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [AW-1:0]    i_q, i_d;
   logic [AW-1:0]    j_q, j_d;
   logic [AW-1:0]    min_q, min_d;
   logic             desc_q, desc_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] rd_fwd;
   logic             load_we;
   logic             swap_we;
   logic             better;

   logic [WIDTH-1:0] mem_q [N];

   sort_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
      .a_i     (mem_q[j_q]),
      .b_i     (mem_q[min_q]),
      .desc_i  (desc_q),
      .better_c(better)
   );

   // Next state, index updates and memory write enables
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      i_d     = i_q;
      j_d     = j_q;
      min_d   = min_q;
      desc_d  = desc_q;
      load_we = 1'b0;
      swap_we = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               desc_d  = descending;
               addr_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               load_we = 1'b1;
               if (addr_q == LAST) begin
                  addr_d  = '0;
                  i_d     = '0;
                  state_d = (N == 1) ? SHOW : ANCHOR;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         ANCHOR: begin
            min_d   = i_q;
            j_d     = i_q + AW'(1);
            state_d = SCAN;
         end
         SCAN: begin
            if (better) min_d = j_q;
            if (j_q == LAST) state_d = SWAP;
            else             j_d = j_q + AW'(1);
         end
         SWAP: begin
            swap_we = (min_q != i_q);
            i_d     = i_q + AW'(1);
            if (i_d == LAST) begin
               addr_d  = '0;
               state_d = SHOW;
            end else begin
               state_d = ANCHOR;
            end
         end
         SHOW: begin
            if (out_valid_q && bus.out_ready) begin
               if (addr_q == LAST) begin
                  addr_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output word for the next cycle, forwarding any write landing this cycle
   always_comb begin
      rd_fwd = mem_q[addr_d];
      if (load_we && (addr_q == addr_d)) rd_fwd = bus.in_data;
      if (swap_we) begin
         if (addr_d == i_q)        rd_fwd = mem_q[min_q];
         else if (addr_d == min_q) rd_fwd = mem_q[i_q];
      end
      in_ready_d  = (state_d == LOAD);
      out_valid_d = (state_d == SHOW);
      out_last_d  = (state_d == SHOW) && (addr_d == LAST);
      busy_d      = (state_d != IDLE);
      out_data_d  = (state_d == SHOW) ? rd_fwd : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         i_q         <= '0;
         j_q         <= '0;
         min_q       <= '0;
         desc_q      <= ORDER_ASC;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         i_q         <= i_d;
         j_q         <= j_d;
         min_q       <= min_d;
         desc_q      <= desc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
      end
   end

   // Element storage; the swap reads both entries before either is updated
   always_ff @(posedge clk) begin
      if (load_we) mem_q[addr_q] <= bus.in_data;
      if (swap_we) begin
         mem_q[i_q]   <= mem_q[min_q];
         mem_q[min_q] <= mem_q[i_q];
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign state         = state_q;

endmodule

// File: tb/tb_sort_engine.sv
// Scoreboard bench for sort_engine: N=5 unsigned, N=5 signed and N=1 instances.
module tb_sort_engine;
   import sort_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   sort_engine_if #(.WIDTH(8)) if0 ();
   sort_engine_if #(.WIDTH(8)) if1 ();
   sort_engine_if #(.WIDTH(8)) if2 ();

   logic       start0, desc0, busy0, done0;
   logic       start1, desc1, busy1, done1;
   logic       start2, desc2, busy2, done2;
   logic [2:0] state0, state1, state2;

   sort_engine #(.N(5), .WIDTH(8), .SIGNED(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .descending(desc0), .bus(if0),
      .busy(busy0), .done(done0), .state(state0));
   sort_engine #(.N(5), .WIDTH(8), .SIGNED(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .descending(desc1), .bus(if1),
      .busy(busy1), .done(done1), .state(state1));
   sort_engine #(.N(1), .WIDTH(8), .SIGNED(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .descending(desc2), .bus(if2),
      .busy(busy2), .done(done2), .state(state2));

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic [7:0] vec [5];
   logic [7:0] expv [5];
   int         rdy_mode = 0;
   int         swaps = 0;
   bit         pend_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // out_ready pattern for instance 0: always, 1-0-0-1 repeating, or held low
   always begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       if0.out_ready = 1'b1;
            1:       begin if0.out_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
            default: if0.out_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) if (rst_n && u0.swap_we) swaps++;

   // Instance 0 monitor: beat data/last against queue head, plus done timing
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         pend_done = 1'b0;
      end else begin
         if (pend_done || done0) check("done_pulse", done0, pend_done);
         pend_done = 1'b0;
         if (if0.out_valid) begin
            e = (q0.size() != 0) ? q0[0] : 9'bx;
            check("beat0", {if0.out_last, if0.out_data}, e);
            if (if0.out_ready && q0.size() != 0) begin
               pend_done = e[8];
               void'(q0.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n && if1.out_valid) begin
         e = (q1.size() != 0) ? q1[0] : 9'bx;
         check("beat_signed", {if1.out_last, if1.out_data}, e);
         if (if1.out_ready && q1.size() != 0) void'(q1.pop_front());
      end
      if (rst_n && if2.out_valid) begin
         e = (q2.size() != 0) ? q2[0] : 9'bx;
         check("beat_n1", {if2.out_last, if2.out_data}, e);
         if (if2.out_ready && q2.size() != 0) void'(q2.pop_front());
      end
   end

   task automatic push_exp0();
      for (int k = 0; k < 5; k++) q0.push_back({(k == 4), expv[k]});
   endtask

   task automatic load0(input logic d, input int gap_at, input bit meas, output int lat);
      start0 = 1'b1;
      desc0  = d;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == gap_at) begin
            if0.in_valid = 1'b0;
            repeat (2) begin
               @(posedge clk); #1;
               check("gap_hold_load", state0, LOAD);
            end
         end
         if0.in_valid = 1'b1;
         if0.in_data  = vec[k];
         @(posedge clk); #1;
      end
      if0.in_valid = 1'b0;
      lat = 0;
      if (meas) begin
         while (!if0.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
         end
      end
   endtask

   task automatic wait_state0(input string name, input logic [2:0] st);
      int c;
      c = 0;
      while (state0 != st && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check(name, state0, st);
   endtask

   task automatic wait_idle0(input string name);
      int c;
      c = 0;
      while (busy0 && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      @(posedge clk); #1;
      check(name, {busy0, q0.size()}, 0);
   endtask

   initial begin
      int lat;
      int c;
      rst_n = 1'b0;
      {start0, desc0, start1, desc1, start2, desc2} = '0;
      if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
      if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;
      #12;
      check("reset_u0", {if0.in_ready, if0.out_valid, if0.out_last, busy0, done0, if0.out_data, state0}, 0);
      check("reset_u2", {if2.in_ready, if2.out_valid, if2.out_last, busy2, done2, if2.out_data, state2}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ascending with latency and swap count
      vec = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5}; expv = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd5};
      swaps = 0;
      push_exp0();
      load0(ORDER_ASC, -1, 1'b1, lat);
      check("latency_n5", lat, 18);
      wait_idle0("asc_complete");
      check("asc_swaps", swaps, 3);

      // Descending with a two-cycle load gap
      expv = '{8'd5, 8'd4, 8'd3, 8'd1, 8'd1};
      push_exp0();
      load0(ORDER_DESC, 2, 1'b1, lat);
      check("latency_gap", lat, 18);
      wait_idle0("desc_complete");

      // Output backpressure 1,0,0,1
      vec = '{8'd9, 8'd3, 8'd7, 8'd3, 8'd0}; expv = '{8'd0, 8'd3, 8'd3, 8'd7, 8'd9};
      rdy_mode = 1;
      push_exp0();
      load0(ORDER_ASC, -1, 1'b0, lat);
      wait_idle0("bp_complete");
      rdy_mode = 0;

      // Reset during SCAN aborts the job
      vec = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
      load0(ORDER_ASC, -1, 1'b0, lat);
      wait_state0("reach_scan", SCAN);
      rst_n = 1'b0;
      #1;
      check("reset_mid_scan", {if0.in_ready, if0.out_valid, if0.out_last, busy0, done0, if0.out_data, state0}, 0);
      q0.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      expv = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      push_exp0();
      load0(ORDER_ASC, -1, 1'b1, lat);
      check("latency_after_reset", lat, 18);
      wait_idle0("after_reset_complete");

      // Already sorted; start held during a stalled SHOW
      vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; expv = vec;
      swaps = 0;
      rdy_mode = 2;
      push_exp0();
      load0(ORDER_ASC, -1, 1'b0, lat);
      wait_state0("reach_show", SHOW);
      start0 = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("start_in_show", state0, SHOW);
      end
      start0 = 1'b0;
      rdy_mode = 0;
      wait_idle0("sorted_complete");
      check("sorted_swaps", swaps, 0);

      // Signed ascending on instance 1
      vec = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01};
      expv = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
      for (int k = 0; k < 5; k++) q1.push_back({(k == 4), expv[k]});
      start1 = 1'b1; desc1 = ORDER_ASC;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if1.in_valid = 1'b1; if1.in_data = vec[k];
         @(posedge clk); #1;
      end
      if1.in_valid = 1'b0;
      c = 0;
      while (busy1 && c < 300) begin @(posedge clk); #1; c++; end
      @(posedge clk); #1;
      check("signed_complete", {busy1, q1.size()}, 0);

      // N=1 goes straight to SHOW
      q2.push_back({1'b1, 8'h2A});
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      if2.in_valid = 1'b1; if2.in_data = 8'h2A;
      @(posedge clk); #1;
      if2.in_valid = 1'b0;
      check("n1_show_now", {if2.out_valid, state2}, {1'b1, SHOW});
      c = 0;
      while (busy2 && c < 50) begin @(posedge clk); #1; c++; end
      @(posedge clk); #1;
      check("n1_complete", {busy2, q2.size()}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised, self-controlled successor of the selection-sort datapath: an internal FSM, no external state input.
- Accepts N words over a valid/ready load stream and sorts them in place by selection sort, ascending or descending, unsigned or signed.
- Streams the sorted result out over a valid/ready interface with a last marker.
- Sits between a data source (switches/UART/FIFO) and a display or consumer stage.

Parameters:
N, 5, number of elements per sort job (1..256)
WIDTH, 8, element bit width (>=1)
SIGNED, 0, 1 = two's-complement comparison, 0 = unsigned
AW, $clog2(N) (min 1), index/address width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
descending  in  1  sort order, latched on accepted start
in_valid  in  1  load word valid
in_ready  out  1  engine accepts load word
in_data  in  WIDTH  load word
out_valid  out  1  sorted word valid
out_ready  in  1  consumer accepts sorted word
out_data  out  WIDTH  sorted word
out_last  out  1  marks element N-1 on the output stream
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output beat is accepted
state  out  3  current FSM state (debug)

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready, out_valid, out_last, busy, done = 0; out_data = 0; all indices = 0. Memory contents are not reset. Reset mid-job aborts the job, with no partial output.
- Encoding: IDLE=0, LOAD=1, ANCHOR=2, SCAN=3, SWAP=4, SHOW=5.
- IDLE:
  - start=1 latches descending, sets addr=0, goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes mem[addr]=in_data and increments addr.
  - The beat with addr==N-1 goes to ANCHOR with i=0, or to SHOW when N==1.
  - Cycles with in_valid low hold state.
- ANCHOR (1 cycle): min=i, j=i+1, go to SCAN.
- SCAN:
  - One compare per cycle.
  - If mem[j] is strictly better than mem[min], min=j. "Better" means less than for ascending, greater than for descending.
  - Signedness follows SIGNED. Ties keep the earlier index.
  - When j==N-1, the compare completes and the FSM goes to SWAP; otherwise j++.
- SWAP (1 cycle):
  - If min!=i, exchange mem[i] and mem[min] in that same cycle. Both reads use pre-swap values; no temp-register lag.
  - i++. If the new i==N-1, go to SHOW with addr=0; else go to ANCHOR.
- Sort latency from the last load beat to first out_valid = N(N-1)/2 + 2(N-1) cycles (N=5: 18). N=1 gives 0.
- SHOW:
  - out_valid=1, out_data=mem[addr], out_last=(addr==N-1).
  - On out_valid&out_ready, addr++.
  - out_data and out_last hold stable while out_ready is low.
  - The final accepted beat goes to IDLE and asserts done for exactly one cycle (the first IDLE cycle).
- busy is 1 in LOAD through SHOW.
- All arithmetic is AW bits wide. Indices never exceed N-1, so there is no wrap.

Decomposition:
- Shared package sort_pkg: the state encoding constants (IDLE..SHOW), the STATE_W=3 constant, and the order encodings ORDER_ASC=0 / ORDER_DESC=1.
- One sub-module, sort_cmp: combinational "a better than b" given WIDTH, SIGNED and descending. It is reusable by future merge/insertion sorters.
- The FSM, memory and indices stay in sort_engine.

Test Plan:
- Ascending, N=5, W=8, SIGNED=0:
  - Load 3,1,4,1,5 with descending=0, out_ready=1.
  - Output is 1,1,3,4,5 with out_last on the 5th beat.
  - First out_valid comes 18 cycles after the last load beat; done pulses once.
- Descending with gaps:
  - Load 3,1,4,1,5 with descending=1, deasserting in_valid for 2 cycles mid-load.
  - Output is 5,4,3,1,1; the gaps stall LOAD with no extra writes.
- Signed, SIGNED=1:
  - Load 0x7F,0x80,0x00,0xFF,0x01 ascending.
  - Output is 0x80,0xFF,0x00,0x01,0x7F.
- Backpressure:
  - Toggle out_ready 1,0,0,1,...
  - Each word appears exactly once, and out_data/out_last stay stable while stalled.
  - done fires only after the 5th accepted beat.
- Reset and start robustness:
  - Pulse rst_n low during SCAN: all outputs go to 0 immediately and the state reads IDLE.
  - A new job (9,8,7,6,5) then yields 5,6,7,8,9.
  - Separately, start asserted during SHOW is ignored.
- Edge cases:
  - N=1: load 0x2A; output 0x2A with out_last=1 immediately after load.
  - Already-sorted input 1,2,3,4,5: no swap writes occur and the output equals the input.
